// File: rtl/ysyx_23060072_dmem_responder_if.sv
// LSU <-> data-memory request/response bus: one valid/ready channel each way.
interface ysyx_23060072_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_23060072_dmem_responder.sv
// Data-memory responder: single outstanding LSU request, fixed access latency,
// byte-strobed stores into a word array, load data or access fault on the response channel.
module ysyx_23060072_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_23060072_dmem_responder_if.slave bus
);
    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W    = 4;
    localparam bit          DIRECT   = (LATENCY == 1);
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lat_wen;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [3:0]       lat_wstrb;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept_c;
    logic             commit_c;
    logic             c_wen;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic [3:0]       c_wstrb;
    logic             c_err;
    logic [IDX_W-1:0] c_idx;

    assign accept_c = (state == S_IDLE) && bus.req_valid;

    // With LATENCY=1 the commit happens on the accepting edge, straight from the request inputs.
    always_comb begin
        c_wen    = lat_wen;
        c_addr   = lat_addr;
        c_wdata  = lat_wdata;
        c_wstrb  = lat_wstrb;
        commit_c = (state == S_WAIT) && (cnt == CNT_W'(1));
        if (DIRECT) begin
            c_wen    = bus.req_wen;
            c_addr   = bus.req_addr;
            c_wdata  = bus.req_wdata;
            c_wstrb  = bus.req_wstrb;
            commit_c = accept_c;
        end
    end

    // Word-aligned base assumed, so the index is a plain subtraction of the word bits.
    assign c_err = (c_addr[1:0] != 2'b00) || (c_addr < BASE_ADDR) || (33'(c_addr) >= END_ADDR);
    assign c_idx = c_addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        lat_wen       <= bus.req_wen;
                        lat_addr      <= bus.req_addr;
                        lat_wdata     <= bus.req_wdata;
                        lat_wstrb     <= bus.req_wstrb;
                        cnt           <= CNT_W'(LATENCY - 1);
                        bus.req_ready <= 1'b0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= S_IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Commit edge: capture the response (load data is the pre-store array value).
            if (commit_c) begin
                state         <= S_RESP;
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= c_err;
                bus.rsp_rdata <= (!c_err && !c_wen) ? mem[c_idx] : 32'h0;
            end
        end
    end

    // Array is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit_c && c_wen && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wstrb[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule
